seg7_bcd_counter_mux: RTL
=========================

// Module: seg7_bcd_counter_mux
// PURPOSE
//   Parametrised multi-digit BCD up/down counter with a time-multiplexed 7-segment driver.
//   Generalises the single-digit 0-9 display counter:
//   - N digits, configurable tick and scan rates
//   - count direction, pause and clear
//   - leading-zero blanking, wrap carry output
//   Sits between the TT top-level pins and the display: seg/dig_sel map to uo_out/uio_out.
// PARAMETERS
//   NUM_DIGITS  4           number of BCD digits (1..8)
//   TICK_DIV    10_000_000  clk cycles per count step (>=2)
//   SCAN_DIV    10_000      clk cycles per displayed digit during scan (>=1)
//   SEG_ACT_LOW 0           1: invert seg outputs (common-anode panel)
// PORTS
//   clk       in   1             clock
//   rst_n     in   1             synchronous active-low reset
//   en        in   1             1: prescaler runs; 0: prescaler and count hold
//   up        in   1             1: count up; 0: count down
//   clear     in   1             synchronous clear of count and prescaler
//   blank_lz  in   1             1: blank leading zero digits
//   seg       out  7             segments, seg[0]=a .. seg[6]=g, registered
//   dig_sel   out  NUM_DIGITS    one-hot digit enable, active high, registered
//   bcd       out  4*NUM_DIGITS  current count; digit i = bcd[4i+3:4i], digit 0 = LSD
//   tick      out  1             1-cycle pulse on each count step
//   carry     out  1             1-cycle pulse on wrap (all-9s->0 up, 0->all-9s down)
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge):
//   - prescaler=0, count=0, scan counter=0, scan index=0
//   - tick=0, carry=0, dig_sel=0
//   - seg=all off (7'h00, or 7'h7F if SEG_ACT_LOW)
//   Prescaler:
//   - counts 0..TICK_DIV-1 while en=1; holds while en=0
//   - at TICK_DIV-1 with en=1: returns to 0, tick=1 that cycle (combinational from state)
//   Count update:
//   - registered on the tick cycle; bcd shows the new value the next cycle
//   - up: digit0 +1, 9->0 ripples +1 into the next digit
//   - down: digit0 -1, 0->9 borrows from the next digit
//   Wrap:
//   - up from all 9s -> all 0s; down from all 0s -> all 9s
//   - carry=1 in the same cycle as that tick, otherwise 0
//   clear:
//   - priority over tick; count=0 and prescaler=0 next cycle; tick/carry suppressed that cycle
//   - clear and en are independent: clear acts even when en=0
//   - first tick after clear release comes exactly TICK_DIV en-cycles later
//   up change: sampled only on tick cycles; no effect on the prescaler
//   Scan (runs continuously, independent of en and clear):
//   - scan counter 0..SCAN_DIV-1
//   - at SCAN_DIV-1: index advances 0,1..NUM_DIGITS-1, then wraps to 0
//   - dig_sel=(1<<index) and seg=decode(digit[index]) are registered every cycle
//   - first cycle after reset release: dig_sel=1, seg=digit 0
//   Decode (gfedcba, active high), 0-9:
//     3F 06 5B 4F 66 6D 7D 07 7F 6F
//   - codes 10-15 unreachable; decode them to 00
//   Blanking: digit i (i>0) is blanked (seg off) when blank_lz=1 and digits i..N-1 are all 0.
//   - digit 0 is never blanked
//   SEG_ACT_LOW=1: seg is the bitwise inverse of the above, including the reset and blank values.
//   Reset mid-operation: all state is dropped; no pending tick/carry survives.
// TESTING  (bench: NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2)
//   1. rst_n=0 for 3 clk, then release
//      -> during reset: tick=carry=0, dig_sel=00, seg=00, bcd=8'h00
//      -> cycle after release: dig_sel=01, seg=3F
//   2. en=1, up=1, run 100 ticks
//      -> bcd steps 00..99 then 00
//      -> tick every 4 clk; carry exactly once, on the 99->00 tick
//   3. from bcd=00: up=0, 1 tick -> bcd=99, carry=1; 10 more ticks -> bcd=89, carry never high
//   4. en=0 for 20 clk -> bcd and prescaler frozen
//      clear=1 at bcd=37 -> bcd=00; next tick 4 en-cycles after clear release
//   5. bcd=05, blank_lz=1
//      -> dig_sel alternates 01/10 every 2 clk; seg=6D on 01, 00 on 10
//      -> bcd=00: 3F on 01, 00 on 10; blank_lz=0 -> 3F on both
//   6. rst_n=0 for one cycle at bcd=42 mid-scan
//      -> bcd=00, index back to 0; no tick or carry in the cycle after release

Source files
------------

// File: rtl/seg7_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with a time-multiplexed 7-segment driver.
// Prescaler and scan timers are down-counters reloaded on terminal count.
module seg7_bcd_counter_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 10_000_000,
  parameter int SCAN_DIV    = 10_000,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clear,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    tick,
  output logic                    carry
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LOAD  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LOAD = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;

  logic [PW-1:0]             pre_cnt;
  logic [4*NUM_DIGITS-1:0]   cnt;
  logic [4*NUM_DIGITS-1:0]   cnt_step;
  logic                      wrap;
  logic [SW-1:0]             scan_cnt;
  logic [IW-1:0]             scan_idx;
  logic [NUM_DIGITS-1:0]     lz_zero;
  logic                      zero_run;
  logic [3:0]                cur_digit;
  logic                      cur_blank;
  logic [NUM_DIGITS-1:0]     sel_next;
  logic [6:0]                seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // The prescaler reloads on reset/clear so the first tick lands TICK_DIV en-cycles later.
  assign tick  = rst_n & en & ~clear & (pre_cnt == '0);
  assign carry = tick & wrap;
  assign bcd   = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pre_cnt <= PRE_LOAD;
    end else if (en) begin
      if (pre_cnt == '0) begin
        pre_cnt <= PRE_LOAD;
      end else begin
        pre_cnt <= pre_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt_step;
    end
  end

  // wrap doubles as the ripple carry/borrow; still set after the top digit means a full wrap.
  always_comb begin
    cnt_step = cnt;
    wrap     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wrap) begin
        if (up) begin
          if (cnt[4*i +: 4] == 4'd9) begin
            cnt_step[4*i +: 4] = 4'd0;
          end else begin
            cnt_step[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
            wrap               = 1'b0;
          end
        end else begin
          if (cnt[4*i +: 4] == 4'd0) begin
            cnt_step[4*i +: 4] = 4'd9;
          end else begin
            cnt_step[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
            wrap               = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    lz_zero  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (cnt[4*i +: 4] == 4'd0);
      lz_zero[i] = zero_run;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    sel_next  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        cur_digit   = cnt[4*i +: 4];
        cur_blank   = blank_lz & (i != 0) & lz_zero[i];
        sel_next[i] = 1'b1;
      end
    end
    seg_next = (cur_blank ? 7'h00 : seg_decode(cur_digit)) ^ {7{SEG_ACT_LOW}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= SCAN_LOAD;
      scan_idx <= '0;
      dig_sel  <= '0;
      seg      <= SEG_OFF;
    end else begin
      if (scan_cnt == '0) begin
        scan_cnt <= SCAN_LOAD;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt - 1'b1;
      end
      dig_sel <= sel_next;
      seg     <= seg_next;
    end
  end

endmodule
